// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline.
// Resolves operand sources in ID and registers them for the EX muxes.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hold,
    input  logic                          clr_cnt,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic                          ex_reg_write,
    input  logic                          ex_mem_read,
    input  logic [REG_ADDR_W-1:0]         ex_dst_addr,
    input  logic                          mem_reg_write,
    input  logic [REG_ADDR_W-1:0]         mem_dst_addr,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic                          stall,
    output logic                          bubble,
    output logic [CNT_W-1:0]              stall_cycles,
    output logic [CNT_W-1:0]              fwd_events
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [3:0]       STALL_INIT = 4'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t               state_q;
    state_t               state_d;
    logic [3:0]           cnt_q;
    logic [3:0]           cnt_d;
    logic [NUM_SRC-1:0]   hit_ex;
    logic [NUM_SRC-1:0]   hit_mem;
    logic [2*NUM_SRC-1:0] sel_nxt;
    logic [2*NUM_SRC-1:0] sel_lat;
    logic                 load_use;
    logic                 stall_c;

    // EX beats MEM so the youngest producer wins
    always_comb begin
        hit_ex  = '0;
        hit_mem = '0;
        sel_nxt = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            hit_ex[k] = id_src_used[k] & ex_reg_write
                      & (ex_dst_addr != '0)
                      & (ex_dst_addr ==
                         id_src_addr[k*REG_ADDR_W +: REG_ADDR_W]);
            hit_mem[k] = id_src_used[k] & mem_reg_write
                       & (mem_dst_addr != '0)
                       & (mem_dst_addr ==
                          id_src_addr[k*REG_ADDR_W +: REG_ADDR_W]);
            if (hit_ex[k]) begin
                sel_nxt[2*k +: 2] = 2'b10;
            end else if (hit_mem[k]) begin
                sel_nxt[2*k +: 2] = 2'b01;
            end
        end
    end

    assign load_use = ex_mem_read & (|hit_ex);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        unique case (state_q)
            RUN: begin
                stall_c = load_use;
                if (load_use && (LOAD_LAT > 1)) begin
                    state_d = STALL;
                    cnt_d   = STALL_INIT;
                end
            end
            STALL: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // load_use is combinational, so mask it while reset is held
    assign stall   = stall_c & rst_n;
    assign bubble  = stall_c & rst_n;
    assign sel_lat = stall_c ? '0 : sel_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            fwd_sel <= '0;
        end else if (!hold) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fwd_sel <= sel_lat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else if (clr_cnt) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else if (!hold) begin
            if (stall_c && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if ((|sel_lat) && (fwd_events != CNT_MAX)) begin
                fwd_events <= fwd_events + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two instances (LOAD_LAT 1 and 3)
// checked every cycle against a behavioural model plus directed literals.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       hold;
    logic       clr_cnt;
    logic [9:0] src;
    logic [1:0] used;
    logic       exw;
    logic       exr;
    logic [4:0] exd;
    logic       memw;
    logic [4:0] memd;

    logic [3:0]  i1_fsel;
    logic        i1_stall;
    logic        i1_bubble;
    logic [15:0] i1_sc;
    logic [15:0] i1_fe;
    logic [3:0]  i2_fsel;
    logic        i2_stall;
    logic        i2_bubble;
    logic [7:0]  i2_sc;
    logic [7:0]  i2_fe;

    int n_cmp = 0;
    int n_err = 0;

    fwd_hazard_unit #(
        .REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .hold(hold), .clr_cnt(clr_cnt),
        .id_src_addr(src), .id_src_used(used),
        .ex_reg_write(exw), .ex_mem_read(exr), .ex_dst_addr(exd),
        .mem_reg_write(memw), .mem_dst_addr(memd),
        .fwd_sel(i1_fsel), .stall(i1_stall), .bubble(i1_bubble),
        .stall_cycles(i1_sc), .fwd_events(i1_fe)
    );

    fwd_hazard_unit #(
        .REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(8)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .hold(hold), .clr_cnt(clr_cnt),
        .id_src_addr(src), .id_src_used(used),
        .ex_reg_write(exw), .ex_mem_read(exr), .ex_dst_addr(exd),
        .mem_reg_write(memw), .mem_dst_addr(memd),
        .fwd_sel(i2_fsel), .stall(i2_stall), .bubble(i2_bubble),
        .stall_cycles(i2_sc), .fwd_events(i2_fe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: per instance, remaining forced stall cycles and counters
    int         m_left [2];
    int         m_sc   [2];
    int         m_fe   [2];
    logic [3:0] m_sel  [2];

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int max_of(int i);
        return (i == 0) ? 65535 : 255;
    endfunction

    function automatic logic hit(int k, logic w, logic [4:0] d);
        logic [4:0] a;
        a = src[k*5 +: 5];
        return used[k] && w && (d != 5'd0) && (d == a);
    endfunction

    function automatic logic [3:0] exp_sel();
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < 2; k++) begin
            if (hit(k, exw, exd)) r[2*k +: 2] = 2'b10;
            else if (hit(k, memw, memd)) r[2*k +: 2] = 2'b01;
        end
        return r;
    endfunction

    function automatic logic lu();
        return exr && (hit(0, exw, exd) || hit(1, exw, exd));
    endfunction

    function automatic logic m_stall(int i);
        return rst_n && ((m_left[i] > 0) || lu());
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_left[i] <= 0;
                m_sc[i]   <= 0;
                m_fe[i]   <= 0;
                m_sel[i]  <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!hold) begin
                    m_sel[i] <= m_stall(i) ? 4'd0 : exp_sel();
                    if (m_left[i] > 0)
                        m_left[i] <= m_left[i] - 1;
                    else if (lu() && lat_of(i) > 1)
                        m_left[i] <= lat_of(i) - 1;
                end
                if (clr_cnt) begin
                    m_sc[i] <= 0;
                    m_fe[i] <= 0;
                end else if (!hold) begin
                    if (m_stall(i) && m_sc[i] < max_of(i))
                        m_sc[i] <= m_sc[i] + 1;
                    if (!m_stall(i) && exp_sel() != 4'd0
                        && m_fe[i] < max_of(i))
                        m_fe[i] <= m_fe[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m1_sel",    int'(i1_fsel),   int'(m_sel[0]));
        chk("m1_stall",  int'(i1_stall),  int'(m_stall(0)));
        chk("m1_bubble", int'(i1_bubble), int'(m_stall(0)));
        chk("m1_sc",     int'(i1_sc),     m_sc[0]);
        chk("m1_fe",     int'(i1_fe),     m_fe[0]);
        chk("m2_sel",    int'(i2_fsel),   int'(m_sel[1]));
        chk("m2_stall",  int'(i2_stall),  int'(m_stall(1)));
        chk("m2_bubble", int'(i2_bubble), int'(m_stall(1)));
        chk("m2_sc",     int'(i2_sc),     m_sc[1]);
        chk("m2_fe",     int'(i2_fe),     m_fe[1]);
    end

    task automatic setin(input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] u, input logic w,
                         input logic r, input logic [4:0] d,
                         input logic mw, input logic [4:0] md);
        src  = {s1, s0};
        used = u;
        exw  = w;
        exr  = r;
        exd  = d;
        memw = mw;
        memd = md;
    endtask

    task automatic idle();
        setin(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n   = 1'b1;
        hold    = 1'b0;
        clr_cnt = 1'b0;
        idle();
        #1 rst_n = 1'b0;
        repeat (2) step();
        chk("rst_sel1", int'(i1_fsel), 0);
        chk("rst_sc1", int'(i1_sc), 0);
        chk("rst_fe1", int'(i1_fe), 0);
        chk("rst_stall2", int'(i2_stall), 0);
        rst_n = 1'b1;
        step();

        // two sources, EX producer for source 0 only
        setin(5'd8, 5'd9, 2'b11, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0);
        #1 chk("t1_stall", int'(i1_stall), 0);
        step();
        idle();
        chk("t1_sel", int'(i1_fsel), 4'b0010);
        chk("t1_fe", int'(i1_fe), 1);

        // EX priority over MEM, then MEM alone
        setin(5'd8, 5'd0, 2'b01, 1'b1, 1'b0, 5'd8, 1'b1, 5'd8);
        step();
        chk("t2_ex", int'(i1_fsel), 4'b0010);
        setin(5'd8, 5'd0, 2'b01, 1'b0, 1'b0, 5'd8, 1'b1, 5'd8);
        step();
        chk("t2_mem", int'(i1_fsel), 4'b0001);
        chk("t2_fe", int'(i1_fe), 3);

        // r0 never forwards; unused sources never forward
        setin(5'd0, 5'd0, 2'b11, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0);
        step();
        chk("t3_zero", int'(i1_fsel), 0);
        setin(5'd5, 5'd5, 2'b00, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5);
        step();
        chk("t3_unused", int'(i1_fsel), 0);
        chk("t3_fe", int'(i1_fe), 3);

        // load-use, LOAD_LAT=1
        setin(5'd8, 5'd0, 2'b01, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
        #1 chk("t4_stall", int'(i1_stall), 1);
        chk("t4_bubble", int'(i1_bubble), 1);
        chk("t4_stall2", int'(i2_stall), 1);
        step();
        chk("t4_sel0", int'(i1_fsel), 0);
        setin(5'd8, 5'd0, 2'b01, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8);
        #1 chk("t4_release", int'(i1_stall), 0);
        chk("t4_stall2b", int'(i2_stall), 1);
        step();
        chk("t4_sel_mem", int'(i1_fsel), 4'b0001);
        chk("t4_sc", int'(i1_sc), 1);
        chk("t4_fe", int'(i1_fe), 4);
        idle();
        repeat (4) step();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("t5_clr", int'(i2_sc), 0);

        // LOAD_LAT=3 with two hold cycles mid-stall
        setin(5'd8, 5'd0, 2'b01, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
        #1 chk("t5_c0", int'(i2_stall), 1);
        step();
        setin(5'd8, 5'd0, 2'b01, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8);
        #1 chk("t5_c1", int'(i2_stall), 1);
        step();
        hold = 1'b1;
        #1 chk("t5_c2", int'(i2_stall), 1);
        step();
        #1 chk("t5_c3", int'(i2_stall), 1);
        step();
        hold = 1'b0;
        #1 chk("t5_c4", int'(i2_stall), 1);
        step();
        #1 chk("t5_c5", int'(i2_stall), 0);
        chk("t5_sc2", int'(i2_sc), 3);
        chk("t5_sc1", int'(i1_sc), 1);
        step();
        chk("t5_sel2", int'(i2_fsel), 4'b0001);

        // reset in the second stall cycle
        idle();
        step();
        setin(5'd8, 5'd0, 2'b01, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
        step();
        #1 rst_n = 1'b0;
        #1 chk("t6_stall2", int'(i2_stall), 0);
        chk("t6_bubble2", int'(i2_bubble), 0);
        chk("t6_sel2", int'(i2_fsel), 0);
        chk("t6_sc2", int'(i2_sc), 0);
        chk("t6_fe2", int'(i2_fe), 0);
        chk("t6_stall1", int'(i1_stall), 0);
        step();
        rst_n = 1'b1;
        idle();
        #1 chk("t6_run", int'(i2_stall), 0);
        setin(5'd8, 5'd0, 2'b01, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
        #1 chk("t6_fresh", int'(i2_stall), 1);

        // continuous stall saturates both counters
        repeat (65540) step();
        chk("sat_sc1", int'(i1_sc), 65535);
        chk("sat_sc2", int'(i2_sc), 255);
        chk("sat_fe1", int'(i1_fe), 0);
        hold    = 1'b1;
        clr_cnt = 1'b1;
        step();
        chk("clr_sc1", int'(i1_sc), 0);
        chk("clr_sc2", int'(i2_sc), 0);
        hold    = 1'b0;
        clr_cnt = 1'b0;
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the 5-stage MIPS pipeline.
- Sits between the ID/EX and EX/MEM pipeline registers.
- Resolves operand hazards one cycle early, while the consumer is still in ID. Source selects are registered, so they arrive at the EX operand muxes as pipeline state.
- Adds load-use stall generation with a configurable stall length, a global hold input, and saturating event counters.

Parameters:
- REG_ADDR_W, 5, register-address width; address 0 is hardwired zero.
- NUM_SRC, 2, number of source operands per instruction.
- LOAD_LAT, 1, load-use stall length in cycles; legal range 1..15.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous reset, active low.
- hold  in  1  global pipeline freeze; all internal state and registered outputs keep their values.
- clr_cnt  in  1  synchronous clear of both event counters.
- id_src_addr  in  NUM_SRC*REG_ADDR_W  source register addresses of the instruction in ID; source k occupies bits [k*REG_ADDR_W +: REG_ADDR_W].
- id_src_used  in  NUM_SRC  source k is actually read by the ID instruction.
- ex_reg_write  in  1  instruction in EX writes a register.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_dst_addr  in  REG_ADDR_W  destination register of the EX instruction.
- mem_reg_write  in  1  instruction in MEM writes a register.
- mem_dst_addr  in  REG_ADDR_W  destination register of the MEM instruction.
- fwd_sel  out  2*NUM_SRC  registered operand selects for the instruction now in EX.
  - 00 = register file, 01 = MEM/WB result, 10 = EX/MEM result, 11 = unused.
- stall  out  1  hold PC and the IF/ID register.
- bubble  out  1  load a NOP into the ID/EX register.
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.
- fwd_events  out  CNT_W  saturating count of fwd_sel latches with at least one nonzero field.

Behaviour:
- Reset (async, rst_n=0):
  - fwd_sel=0, stall_cycles=0, fwd_events=0, FSM=RUN, stall counter=0.
  - stall and bubble read 0 while reset is asserted.
- Match rule for each source k:
  - hitEX_k = id_src_used[k] & ex_reg_write & ex_dst_addr!=0 & ex_dst_addr==src_k.
  - hitMEM_k is the same test against mem_reg_write and mem_dst_addr.
- Next-select for source k:
  - hitEX_k -> 10 (the producer will be in MEM when the consumer is in EX).
  - Otherwise hitMEM_k -> 01.
  - Otherwise 00.
  - EX has priority over MEM, which guarantees the youngest value.
- The register file is write-through. A producer in WB needs no forwarding.
- load_use = ex_mem_read & (OR over k of hitEX_k).
- FSM states RUN and STALL; 4-bit down-counter cnt.
  - In RUN: stall = bubble = load_use.
  - In STALL: stall = bubble = 1.
  - RUN & load_use & !hold & LOAD_LAT>1 -> STALL, cnt <= LOAD_LAT-1.
  - RUN & load_use & LOAD_LAT==1 -> remain in RUN. The load has advanced to MEM, so the hit clears next cycle.
  - STALL & !hold -> cnt decrements. Transition to RUN on the edge where cnt==1.
  - While in STALL, load_use is not re-evaluated.
- fwd_sel update, on each edge with !hold:
  - If bubble=1, fwd_sel <= 0, because a bubble is entering EX.
  - Otherwise fwd_sel <= next-select.
- Latency: selects computed in ID cycle n are visible on fwd_sel in cycle n+1, aligned with the ID/EX register.
- After a LOAD_LAT=1 stall, the consumer re-evaluates against the load now in MEM and latches 01.
- hold=1 freezes fwd_sel, the FSM, cnt and both counters. stall and bubble still follow their combinational equations.
- Counters, on each edge with !hold:
  - stall_cycles increments when stall=1.
  - fwd_events increments when the value being latched into fwd_sel is nonzero.
  - Both saturate at all-ones and do not wrap.
- clr_cnt zeroes both counters and takes priority over increment and hold.
- Simultaneous hit on all NUM_SRC sources: every field is set independently. There is no single-source priority between fields.
- Reset asserted mid-STALL: returns to RUN immediately. The first post-reset cycle evaluates the inputs afresh.

Test Plan:
1. ex_reg_write=1, ex_dst=8; ID sources 8 and 9, both used -> next cycle fwd_sel = {00,10}; stall=0; fwd_events=1.
2. ex_dst=8 and mem_dst=8, both writing; ID source 0 = 8 -> fwd_sel[1:0]=10 (EX priority). With ex_reg_write=0 instead -> 01.
3. ex_dst=0 with writes enabled; source address 0 -> fwd_sel=00. A matching address with id_src_used=0 -> 00.
4. LOAD_LAT=1: load to $t0 in EX, ID reads $t0 -> stall=bubble=1 for one cycle, fwd_sel<=00. Next cycle (load in MEM) -> fwd_sel=01; stall_cycles=1.
5. LOAD_LAT=3, same stimulus -> stall high exactly 3 cycles. Hold asserted for 2 cycles mid-stall -> stall high 5 cycles total; stall_cycles=3.
6. Reset pulsed in the second STALL cycle -> all outputs 0 immediately, FSM in RUN. Counter saturation: preload via 2^CNT_W stall cycles -> value holds at all-ones. clr_cnt -> 0.
